// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier (3 stages) with valid/ready handshake, signed/unsigned mode and tag passthrough.
// Optional multiply-accumulate enabled by defining BOOTH_MUL_ACCUM_EN.
module booth_mul_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef BOOTH_MUL_ACCUM_EN
   input  logic               in_acc,
   input  logic               in_acc_clr,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_result,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int EW = WIDTH + 2;
   localparam int N  = EW / 2;
   localparam int M  = N + 1;
   localparam int PW = 2 * WIDTH;

   // Handshake: a transfer happens on a side when valid & ready are both high at the
   // rising edge. The whole pipe moves as one (advance) or holds as one; in_ready
   // depends only on out_valid/out_ready, so no path exists from in_valid to in_ready.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   logic [N-1:0][PW-1:0] pp_c;
   logic [PW-1:0]        corr_c;

   always_comb begin
      logic [PW-1:0] a_ext;
      logic [EW:0]   b_pad;
      logic [2:0]    grp;
      logic [PW-1:0] mag;
      logic          neg;
      pp_c   = '0;
      corr_c = '0;
      a_ext  = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
      b_pad  = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
      for (int i = 0; i < N; i++) begin
         grp = b_pad[2*i +: 3];
         mag = '0;
         neg = 1'b0;
         case (grp)
            3'b001, 3'b010: mag = a_ext;
            3'b011:         mag = a_ext << 1;
            3'b100:         begin mag = a_ext << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_ext; neg = 1'b1; end
            default:        mag = '0;
         endcase
         // Full sign extension at 2*WIDTH; the +1 of the negation lands in corr_c.
         pp_c[i]       = (neg ? ~mag : mag) << (2*i);
         corr_c[2*i]   = neg;
      end
   end

   // Carry-save reduction by repeated 3:2 levels until two rows remain.
   function automatic logic [2*PW-1:0] csa_tree(input logic [M-1:0][PW-1:0] rows_in);
      logic [M-1:0][PW-1:0] rows;
      logic [M-1:0][PW-1:0] nxt;
      int cnt;
      int nc;
      int full;
      rows = rows_in;
      cnt  = M;
      for (int lvl = 0; lvl < M; lvl++) begin
         if (cnt > 2) begin
            nxt  = '0;
            nc   = 0;
            full = (cnt / 3) * 3;
            for (int j = 0; j < M; j++) begin
               if (j < full && (j % 3) == 0) begin
                  nxt[nc]     = rows[j] ^ rows[j+1] ^ rows[j+2];
                  nxt[nc+1]   = ((rows[j] & rows[j+1]) | (rows[j] & rows[j+2]) |
                                 (rows[j+1] & rows[j+2])) << 1;
                  nc          = nc + 2;
               end else if (j >= full && j < cnt) begin
                  nxt[nc] = rows[j];
                  nc      = nc + 1;
               end
            end
            rows = nxt;
            cnt  = nc;
         end
      end
      return {rows[1], rows[0]};
   endfunction

   logic                 s1_valid;
   logic [N-1:0][PW-1:0] s1_pp;
   logic [PW-1:0]        s1_corr;
   logic [TAG_W-1:0]     s1_tag;
   logic                 s2_valid;
   logic [PW-1:0]        s2_sum;
   logic [PW-1:0]        s2_carry;
   logic [TAG_W-1:0]     s2_tag;
   logic [2*PW-1:0]      tree_out;
   logic [PW-1:0]        result_c;

   assign tree_out = csa_tree({s1_corr, s1_pp});

`ifdef BOOTH_MUL_ACCUM_EN
   logic          s1_acc, s1_acc_clr, s2_acc, s2_acc_clr;
   logic [PW-1:0] acc_reg;
   assign result_c = s2_sum + s2_carry + ((s2_acc && !s2_acc_clr) ? acc_reg : '0);
`else
   assign result_c = s2_sum + s2_carry;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_pp      <= '0;
         s1_corr    <= '0;
         s1_tag     <= '0;
         s2_valid   <= 1'b0;
         s2_sum     <= '0;
         s2_carry   <= '0;
         s2_tag     <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
`ifdef BOOTH_MUL_ACCUM_EN
         s1_acc     <= 1'b0;
         s1_acc_clr <= 1'b0;
         s2_acc     <= 1'b0;
         s2_acc_clr <= 1'b0;
         acc_reg    <= '0;
`endif
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (in_valid) begin
            s1_pp   <= pp_c;
            s1_corr <= corr_c;
            s1_tag  <= in_tag;
`ifdef BOOTH_MUL_ACCUM_EN
            s1_acc     <= in_acc;
            s1_acc_clr <= in_acc_clr;
`endif
         end
         if (s1_valid) begin
            s2_sum   <= tree_out[PW-1:0];
            s2_carry <= tree_out[2*PW-1:PW];
            s2_tag   <= s1_tag;
`ifdef BOOTH_MUL_ACCUM_EN
            s2_acc     <= s1_acc;
            s2_acc_clr <= s1_acc_clr;
`endif
         end
         if (s2_valid) begin
            out_result <= result_c;
            out_tag    <= s2_tag;
`ifdef BOOTH_MUL_ACCUM_EN
            acc_reg    <= result_c;
`endif
         end
      end
   end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Directed testbench for booth_mul_pipe (WIDTH=32); covers the accumulate path when BOOTH_MUL_ACCUM_EN is defined.
module tb_booth_mul_pipe;

   localparam int W  = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_signed;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] out_result;
   logic [TW-1:0] out_tag;
`ifdef BOOTH_MUL_ACCUM_EN
   logic          in_acc;
   logic          in_acc_clr;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   logic [2*W-1:0] exp_q[$];
   logic [TW-1:0]  tag_q[$];

   localparam logic [W-1:0] A_TAB [8] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007,
                                          32'h1234_5678, 32'h0000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
   localparam logic [W-1:0] B_TAB [8] = '{32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 32'hFFFF_FFFD,
                                          32'h0000_0100, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0010};
   localparam logic         S_TAB [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   booth_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_signed  (in_signed),
      .in_tag     (in_tag),
`ifdef BOOTH_MUL_ACCUM_EN
      .in_acc     (in_acc),
      .in_acc_clr (in_acc_clr),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      sa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      sb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return sa * sb;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [TW-1:0] t);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_tag    = t;
   endtask

   // One operation in isolation: result must appear exactly 3 cycles after accept.
   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] t, input logic [2*W-1:0] exp);
      drive(a, b, s, t);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
      tick;
      in_valid = 1'b0;
      tick;
      chk({name, "_early"}, 64'(out_valid), 64'd0);
      tick;
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_result"}, out_result, exp);
      chk({name, "_tag"}, 64'(out_tag), 64'(t));
   endtask

   initial begin
      int n_out;
      int first_c;
      int last_c;
      logic [2*W-1:0] held;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      in_tag    = '0;
      out_ready = 1'b1;
`ifdef BOOTH_MUL_ACCUM_EN
      in_acc     = 1'b0;
      in_acc_clr = 1'b0;
`endif

      // Reset state
      tick;
      tick;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_result", out_result, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      tick;

      // Directed corner products
      run_op("s_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h5, 64'h0000_0000_0000_0001);
      run_op("u_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'hA, 64'hFFFF_FFFE_0000_0001);
      run_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 4'h3, 64'h4000_0000_0000_0000);
      run_op("s_min_one", 32'h8000_0000, 32'h0000_0001, 1'b1, 4'hC, 64'hFFFF_FFFF_8000_0000);
      run_op("u_min_two", 32'h8000_0000, 32'h0000_0002, 1'b0, 4'h1, 64'h0000_0001_0000_0000);
      run_op("s_7_m3", 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 4'h9, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("u_max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 4'h6, 64'h3FFF_FFFF_0000_0001);

      // Back-to-back: 8 ops, tags 0..7, out_ready high
      tick;
      n_out   = 0;
      first_c = -1;
      last_c  = -1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            drive(A_TAB[c], B_TAB[c], S_TAB[c], TW'(c));
            exp_q.push_back(model(A_TAB[c], B_TAB[c], S_TAB[c]));
            tag_q.push_back(TW'(c));
         end else begin
            in_valid = 1'b0;
         end
         tick;
         if (out_valid) begin
            if (n_out == 0) first_c = c;
            last_c = c;
            n_out++;
            if (exp_q.size() > 0) begin
               chk("b2b_result", out_result, exp_q.pop_front());
               chk("b2b_tag", 64'(out_tag), 64'(tag_q.pop_front()));
            end
         end
      end
      chk("b2b_count", 64'(n_out), 64'd8);
      chk("b2b_first_cycle", 64'(first_c), 64'd2);
      chk("b2b_last_cycle", 64'(last_c), 64'd9);

      // Backpressure: tags 1,2,3 then stall 5 cycles
      for (int t = 1; t <= 3; t++) begin
         drive(32'(t * 1000), 32'd7, 1'b1, TW'(t));
         tick;
      end
      chk("bp_head_valid", 64'(out_valid), 64'd1);
      chk("bp_head_tag", 64'(out_tag), 64'd1);
      out_ready = 1'b0;
      drive(32'hFFFF_0000, 32'h1234_0000, 1'b0, 4'hF);
      #1;
      held = out_result;
      chk("bp_head_result", held, 64'd7000);
      for (int k = 0; k < 5; k++) begin
         chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
         tick;
         chk("bp_stall_valid", 64'(out_valid), 64'd1);
         chk("bp_stall_tag", 64'(out_tag), 64'd1);
         chk("bp_stall_result", out_result, held);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick;
      chk("bp_rel_tag2", 64'(out_tag), 64'd2);
      chk("bp_rel_res2", out_result, 64'd14000);
      tick;
      chk("bp_rel_tag3", 64'(out_tag), 64'd3);
      chk("bp_rel_res3", out_result, 64'd21000);
      tick;
      chk("bp_no_junk", 64'(out_valid), 64'd0);

      // Reset mid-flight
      drive(32'd11, 32'd13, 1'b0, 4'h2);
      tick;
      drive(32'd17, 32'd19, 1'b0, 4'h4);
      tick;
      in_valid = 1'b0;
      tick;
      chk("mid_pre_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_result", out_result, 64'd0);
      tick;
      rst = 1'b0;
      tick;
      tick;
      tick;
      chk("mid_flushed", 64'(out_valid), 64'd0);
      run_op("post_rst_3x5", 32'd3, 32'd5, 1'b1, 4'h7, 64'd15);

`ifdef BOOTH_MUL_ACCUM_EN
      // Accumulate: (2,3,clr) -> 6, (4,5,acc) -> 26, (-1,7,acc) -> 19, gaps and a stall
      tick;
      in_acc_clr = 1'b1;
      run_op("acc_op1", 32'd2, 32'd3, 1'b1, 4'h1, 64'd6);
      in_acc_clr = 1'b0;
      for (int k = 0; k < 4; k++) tick;
      in_acc = 1'b1;
      drive(32'd4, 32'd5, 1'b1, 4'h2);
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("acc_op2_stall", out_result, 64'd26);
      end
      out_ready = 1'b1;
      tick;
      for (int k = 0; k < 4; k++) tick;
      run_op("acc_op3", 32'hFFFF_FFFF, 32'd7, 1'b1, 4'h3, 64'd19);
      in_acc = 1'b0;
`endif

      tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
